bubble_dout_engine: RTL and testbench

//  Parametrised, double-buffered bubble data output engine for NCH channels (1/2/4), successor to the fixed 2-line BubbleInterface.

---
 rtl/bubble_pkg.sv | 25 ++
 rtl/bubble_bitram.sv | 29 ++
 rtl/bubble_dout_engine.sv | 182 ++++++++++++++++++
 tb/tb_bubble_dout_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bubble_pkg.sv
// Shared encodings for the bubble data output path: access types, tick indices
// and the output engine state type.
package bubble_pkg;

    localparam logic [2:0] ACC_IDLE = 3'b000;
    localparam logic [2:0] ACC_BOOT = 3'b001;
    localparam logic [2:0] ACC_USER = 3'b010;

    localparam logic [1:0] TICK_RD  = 2'd0;
    localparam logic [1:0] TICK_OUT = 2'd1;
    localparam logic [1:0] TICK_END = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2,
        ST_STALL  = 2'd3
    } eng_state_t;

    // Only boot and user accesses drive data; every other code behaves as idle.
    function automatic logic acc_active(input logic [2:0] acc);
        return (acc == ACC_BOOT) || (acc == ACC_USER);
    endfunction

endpackage

// File: rtl/bubble_bitram.sv
// Two-bank page store: bit-wide write port, one NCH-bit row per bit cycle on a
// registered read port (one column per channel).
module bubble_bitram
    import bubble_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int CYCW = 13,
    parameter int CHW  = 1
) (
    input  logic            clk,
    input  logic            we,
    input  logic            wbank,
    input  logic [CYCW-1:0] wrow,
    input  logic [CHW-1:0]  wch,
    input  logic            wdata,
    input  logic            re,
    input  logic            rbank,
    input  logic [CYCW-1:0] raddr,
    output logic [NCH-1:0]  rdata
);

    logic [NCH-1:0] mem [2][2**CYCW];

    always_ff @(posedge clk) begin
        if (we) mem[wbank][wrow][wch] <= wdata;
        if (re) rdata <= mem[rbank][raddr];
    end

endmodule

// File: rtl/bubble_dout_engine.sv
// Double-buffered bubble data output engine: one bank is filled by the loader
// while the other streams to DOUT, paced by the bit-cycle/tick counters.
module bubble_dout_engine
    import bubble_pkg::*;
#(
    parameter int   NCH      = 2,
    parameter int   CYCW     = 13,
    parameter int   LAST_CYC = 4095,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic                          MCLK,
    input  logic                          nRST,
    input  logic [2:0]                    ACCTYPE,
    input  logic [CYCW-1:0]               BOUTCYCLENUM,
    input  logic [1:0]                    BOUTTICKS,
    input  logic                          nOUTBUFWCLKEN,
    input  logic [CYCW+$clog2(NCH)-1:0]   OUTBUFWADDR,
    input  logic                          OUTBUFWDATA,
    input  logic                          WCOMMIT,
    output logic [NCH-1:0]                DOUT,
    output logic                          BANKFREE,
    output logic                          UNDERRUN,
    output logic                          OVERRUN,
    output logic [1:0]                    dbg_state
);

    localparam int             CHW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int             AW     = CYCW + $clog2(NCH);
    localparam logic [NCH-1:0] IDLE_V = {NCH{IDLE_LVL}};
    localparam logic [CYCW-1:0] LAST_V = CYCW'(LAST_CYC);

    eng_state_t     state, state_nxt;
    logic           rbank, rbank_nxt, wbank;
    logic [1:0]     full, full_nxt;
    logic [NCH-1:0] dout_q, dout_nxt, rd_data;
    logic           underrun_q, underrun_nxt;
    logic           overrun_q, overrun_nxt;
    logic           bankfree_q, bankfree_nxt;
    logic           rd_valid, rd_en, we;
    logic           acc_on, any_full, commit_ok, page_end, start_ok;
    logic [CYCW-1:0] wrow;
    logic [CHW-1:0]  wch;

    generate
        if (NCH > 1) begin : g_multi
            assign wrow = OUTBUFWADDR[AW-1:CHW];
            assign wch  = OUTBUFWADDR[CHW-1:0];
        end else begin : g_single
            assign wrow = OUTBUFWADDR;
            assign wch  = '0;
        end
    endgenerate

    // Loader handshake: a write lands when nOUTBUFWCLKEN is low at an MCLK edge and
    // the write bank is not yet full; WCOMMIT hands the bank over, BANKFREE says it is empty.
    assign wbank     = ~rbank;
    assign acc_on    = acc_active(ACCTYPE);
    assign any_full  = |full;
    assign commit_ok = WCOMMIT && !full[wbank];
    assign page_end  = (BOUTTICKS == TICK_END) && (BOUTCYCLENUM == LAST_V);
    assign start_ok  = (BOUTTICKS == TICK_RD) && (BOUTCYCLENUM == '0);
    assign rd_en     = (BOUTTICKS == TICK_RD);
    assign we        = !nOUTBUFWCLKEN && !full[wbank];

    bubble_bitram #(.NCH(NCH), .CYCW(CYCW), .CHW(CHW)) u_ram (
        .clk   (MCLK),
        .we    (we),
        .wbank (wbank),
        .wrow  (wrow),
        .wch   (wch),
        .wdata (OUTBUFWDATA),
        .re    (rd_en),
        .rbank (rbank),
        .raddr (BOUTCYCLENUM),
        .rdata (rd_data)
    );

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ST_IDLE;
            rbank      <= 1'b0;
            full       <= 2'b00;
            dout_q     <= IDLE_V;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            bankfree_q <= 1'b1;
            rd_valid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rbank      <= rbank_nxt;
            full       <= full_nxt;
            dout_q     <= dout_nxt;
            underrun_q <= underrun_nxt;
            overrun_q  <= overrun_nxt;
            bankfree_q <= bankfree_nxt;
            if (rd_en) rd_valid <= (BOUTCYCLENUM <= LAST_V);
        end
    end

    always_comb begin
        state_nxt    = state;
        rbank_nxt    = rbank;
        full_nxt     = full;
        dout_nxt     = dout_q;
        underrun_nxt = underrun_q;
        overrun_nxt  = 1'b0;

        if (WCOMMIT) begin
            if (commit_ok) full_nxt[wbank] = 1'b1;
            else           overrun_nxt     = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                dout_nxt = IDLE_V;
                if (full[rbank]) begin
                    state_nxt = ST_ARMED;
                end else if (full[wbank]) begin
                    rbank_nxt = wbank;
                    state_nxt = ST_ARMED;
                end else if (acc_on) begin
                    state_nxt    = ST_STALL;
                    underrun_nxt = 1'b1;
                end
            end
            ST_ARMED: begin
                dout_nxt = IDLE_V;
                if (!full[rbank] && full[wbank]) rbank_nxt = wbank;
                if (acc_on) begin
                    if (!any_full) begin
                        state_nxt    = ST_STALL;
                        underrun_nxt = 1'b1;
                    end else if (start_ok && full[rbank]) begin
                        state_nxt = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (!acc_on) begin
                    // Abort keeps the page so the next access replays it.
                    state_nxt = ST_ARMED;
                    dout_nxt  = IDLE_V;
                end else begin
                    if (BOUTTICKS == TICK_OUT) dout_nxt = rd_valid ? rd_data : IDLE_V;
                    if (page_end) begin
                        full_nxt[rbank] = 1'b0;
                        if (full[wbank] || commit_ok) begin
                            rbank_nxt = wbank;
                        end else begin
                            state_nxt = ST_IDLE;
                            dout_nxt  = IDLE_V;
                        end
                    end
                end
            end
            ST_STALL: begin
                dout_nxt = IDLE_V;
                if (commit_ok) underrun_nxt = 1'b0;
                if (!acc_on) begin
                    if (full[rbank]) begin
                        state_nxt = ST_ARMED;
                    end else if (full[wbank]) begin
                        rbank_nxt = wbank;
                        state_nxt = ST_ARMED;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        bankfree_nxt = ~full_nxt[~rbank_nxt];
    end

    assign DOUT      = dout_q;
    assign BANKFREE  = bankfree_q;
    assign UNDERRUN  = underrun_q;
    assign OVERRUN   = overrun_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_bubble_dout_engine.sv
// Directed bench for bubble_dout_engine with a 4-channel, 12-cycle page.
module tb_bubble_dout_engine;
    import bubble_pkg::*;

    localparam int NCH  = 4;
    localparam int CYCW = 4;
    localparam int LAST = 11;

    logic            MCLK = 1'b0;
    logic            nRST = 1'b0;
    logic [2:0]      ACCTYPE = ACC_IDLE;
    logic [CYCW-1:0] BOUTCYCLENUM = '0;
    logic [1:0]      BOUTTICKS = '0;
    logic            nOUTBUFWCLKEN = 1'b1;
    logic [5:0]      OUTBUFWADDR = '0;
    logic            OUTBUFWDATA = 1'b0;
    logic            WCOMMIT = 1'b0;
    logic [NCH-1:0]  DOUT;
    logic            BANKFREE, UNDERRUN, OVERRUN;
    logic [1:0]      dbg_state;

    int errors = 0;
    int checks = 0;

    bubble_dout_engine #(.NCH(NCH), .CYCW(CYCW), .LAST_CYC(LAST), .IDLE_LVL(1'b1)) dut (
        .MCLK          (MCLK),
        .nRST          (nRST),
        .ACCTYPE       (ACCTYPE),
        .BOUTCYCLENUM  (BOUTCYCLENUM),
        .BOUTTICKS     (BOUTTICKS),
        .nOUTBUFWCLKEN (nOUTBUFWCLKEN),
        .OUTBUFWADDR   (OUTBUFWADDR),
        .OUTBUFWDATA   (OUTBUFWDATA),
        .WCOMMIT       (WCOMMIT),
        .DOUT          (DOUT),
        .BANKFREE      (BANKFREE),
        .UNDERRUN      (UNDERRUN),
        .OVERRUN       (OVERRUN),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 MCLK = ~MCLK;

    function automatic logic [3:0] pat(input int sel, input int k);
        logic [3:0] kk;
        kk = k[3:0];
        return (sel == 0) ? kk : (kk ^ 4'hA);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic tick(input int cyc, input int t);
        BOUTCYCLENUM = cyc[3:0];
        BOUTTICKS    = t[1:0];
        step();
    endtask

    task automatic fill(input int sel, input int nrows, input bit inv);
        logic [3:0] v;
        for (int k = 0; k < nrows; k++) begin
            v = pat(sel, k);
            for (int ch = 0; ch < NCH; ch++) begin
                nOUTBUFWCLKEN = 1'b0;
                OUTBUFWADDR   = {k[3:0], ch[1:0]};
                OUTBUFWDATA   = v[ch] ^ inv;
                step();
            end
        end
        nOUTBUFWCLKEN = 1'b1;
    endtask

    task automatic commit();
        WCOMMIT = 1'b1;
        step();
        WCOMMIT = 1'b0;
    endtask

    // Drive ncyc bit cycles; DOUT is checked once it has settled (tick 2 window).
    task automatic run_page(input int sel, input int ncyc, input int commit_cyc,
                            input int prev_sel, input string tag);
        for (int c = 0; c < ncyc; c++) begin
            WCOMMIT = (c == commit_cyc);
            tick(c, 0);
            WCOMMIT = 1'b0;
            if (c == 0 && prev_sel >= 0) chk({tag, "_gap"}, DOUT, pat(prev_sel, LAST));
            tick(c, 1);
            chk(tag, DOUT, pat(sel, c));
            tick(c, 2);
            tick(c, 3);
        end
    endtask

    initial begin
        repeat (3) @(posedge MCLK);
        #1;
        chk("rst_dout", DOUT, 4'hF);
        chk("rst_bankfree", BANKFREE, 1'b1);
        chk("rst_underrun", UNDERRUN, 1'b0);
        chk("rst_overrun", OVERRUN, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        nRST = 1'b1;
        step();

        // first page committed, engine arms on it
        fill(0, LAST + 1, 1'b0);
        commit();
        chk("commit1_bankfree", BANKFREE, 1'b0);
        chk("commit1_state", dbg_state, ST_IDLE);
        step();
        chk("armed_state", dbg_state, ST_ARMED);
        chk("armed_bankfree", BANKFREE, 1'b1);
        chk("armed_dout", DOUT, 4'hF);

        // ping-pong: second page written ahead, committed mid-page
        fill(1, LAST + 1, 1'b0);
        ACCTYPE = ACC_USER;
        run_page(0, LAST + 1, 5, -1, "page0");
        chk("pp_bankfree", BANKFREE, 1'b1);
        chk("pp_state", dbg_state, ST_STREAM);
        run_page(1, LAST + 1, -1, 0, "page1");
        ACCTYPE = ACC_IDLE;
        step();
        chk("end_state", dbg_state, ST_IDLE);
        chk("end_dout", DOUT, 4'hF);
        chk("end_underrun", UNDERRUN, 1'b0);

        // underrun
        ACCTYPE = ACC_BOOT;
        step();
        chk("ur_state", dbg_state, ST_STALL);
        chk("ur_flag", UNDERRUN, 1'b1);
        chk("ur_dout", DOUT, 4'hF);
        fill(1, LAST + 1, 1'b0);
        chk("ur_sticky", UNDERRUN, 1'b1);
        commit();
        chk("ur_clear", UNDERRUN, 1'b0);
        chk("ur_dout2", DOUT, 4'hF);
        ACCTYPE = ACC_IDLE;
        step();
        chk("ur_rearm", dbg_state, ST_ARMED);
        chk("ur_bankfree", BANKFREE, 1'b1);

        // overrun with both banks full; writes into the full bank are dropped
        fill(0, LAST + 1, 1'b0);
        commit();
        chk("ov_bankfree", BANKFREE, 1'b0);
        chk("ov_accept", OVERRUN, 1'b0);
        fill(0, 4, 1'b1);
        WCOMMIT = 1'b1;
        step();
        WCOMMIT = 1'b0;
        chk("ov_pulse", OVERRUN, 1'b1);
        step();
        chk("ov_pulse_end", OVERRUN, 1'b0);
        chk("ov_bankfree2", BANKFREE, 1'b0);

        // abort mid-page, replay, then the untouched second bank
        ACCTYPE = ACC_USER;
        run_page(1, 6, -1, -1, "abort_pre");
        ACCTYPE = ACC_IDLE;
        tick(6, 0);
        chk("abort_dout", DOUT, 4'hF);
        chk("abort_state", dbg_state, ST_ARMED);
        chk("abort_bankfree", BANKFREE, 1'b0);
        ACCTYPE = ACC_BOOT;
        run_page(1, LAST + 1, -1, -1, "replay");
        run_page(0, LAST + 1, -1, 1, "kept_bank");
        ACCTYPE = ACC_IDLE;
        step();
        chk("final_state", dbg_state, ST_IDLE);
        chk("final_dout", DOUT, 4'hF);
        chk("final_bankfree", BANKFREE, 1'b1);

        // asynchronous reset while streaming
        fill(0, LAST + 1, 1'b0);
        commit();
        step();
        fill(1, LAST + 1, 1'b0);
        commit();
        chk("pre_rst_bankfree", BANKFREE, 1'b0);
        ACCTYPE = ACC_USER;
        run_page(0, 3, -1, -1, "pre_rst");
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_dout", DOUT, 4'hF);
        chk("arst_bankfree", BANKFREE, 1'b1);
        chk("arst_underrun", UNDERRUN, 1'b0);
        chk("arst_state", dbg_state, ST_IDLE);
        ACCTYPE = ACC_IDLE;
        step();
        nRST = 1'b1;
        step();
        chk("post_rst_state", dbg_state, ST_IDLE);
        chk("post_rst_dout", DOUT, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
